// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory bus between instruction fetch
//               and data access, one outstanding transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush_i,
   input  logic                  if_req_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   output logic                  if_rvalid_o,
   output logic [DATA_W-1:0]     if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [DATA_W/8-1:0]   dm_be_i,
   input  logic [ADDR_W-1:0]     dm_addr_i,
   input  logic [DATA_W-1:0]     dm_wdata_i,
   output logic                  dm_rvalid_o,
   output logic [DATA_W-1:0]     dm_rdata_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [DATA_W/8-1:0]   bus_be_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   input  logic                  bus_gnt_i,
   input  logic                  bus_rvalid_i,
   input  logic [DATA_W-1:0]     bus_rdata_i,
   output logic                  stall_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_owner_dm;
   logic                r_discard;
   logic                r_if_done;
   logic                r_dm_done;
   logic [CNT_W-1:0]    r_starve_cnt;
   logic                r_we;
   logic [BE_W-1:0]     r_be;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_dm_rdata;

   logic w_if_pend;
   logic w_dm_pend;
   logic w_issue;
   logic w_pick_if;
   logic w_resp;
   logic w_starved;

   // A flushed fetch may not win arbitration in the flush cycle itself.
   assign w_if_pend = if_req_i & ~r_if_done & ~flush_i;
   assign w_dm_pend = dm_req_i & ~r_dm_done;
   assign w_starved = (r_starve_cnt == CNT_W'(MAX_WAIT));
   assign w_issue   = reset_n & (r_state == S_IDLE) & (w_if_pend | w_dm_pend);
   assign w_pick_if = w_if_pend & (~w_dm_pend | w_starved);
   assign w_resp    = reset_n & (r_state == S_RESP) & bus_rvalid_i;

   assign if_rvalid_o = w_resp & ~r_owner_dm & ~r_discard & ~flush_i;
   assign dm_rvalid_o = w_resp & r_owner_dm;
   assign if_rdata_o  = if_rvalid_o ? bus_rdata_i : r_if_rdata;
   assign dm_rdata_o  = dm_rvalid_o ? bus_rdata_i : r_dm_rdata;

   assign stall_o = reset_n & ((if_req_i & ~r_if_done & ~if_rvalid_o) |
                               (dm_req_i & ~r_dm_done & ~dm_rvalid_o));

   always_comb begin
      w_state_nxt = r_state;
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_be_o    = '0;
      bus_addr_o  = '0;
      bus_wdata_o = '0;
      if (reset_n) begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  bus_req_o = 1'b1;
                  if (w_pick_if) begin
                     bus_be_o   = '1;
                     bus_addr_o = if_addr_i;
                  end else begin
                     bus_we_o    = dm_we_i;
                     bus_be_o    = dm_be_i;
                     bus_addr_o  = dm_addr_i;
                     bus_wdata_o = dm_wdata_i;
                  end
                  w_state_nxt = bus_gnt_i ? S_RESP : S_ADDR;
               end
            end
            S_ADDR: begin
               bus_req_o   = 1'b1;
               bus_we_o    = r_we;
               bus_be_o    = r_be;
               bus_addr_o  = r_addr;
               bus_wdata_o = r_wdata;
               if (bus_gnt_i) begin
                  w_state_nxt = S_RESP;
               end
            end
            S_RESP: begin
               if (bus_rvalid_i) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_owner_dm   <= 1'b0;
         r_discard    <= 1'b0;
         r_if_done    <= 1'b0;
         r_dm_done    <= 1'b0;
         r_starve_cnt <= '0;
         r_we         <= 1'b0;
         r_be         <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue) begin
            r_owner_dm <= ~w_pick_if;
            r_we       <= bus_we_o;
            r_be       <= bus_be_o;
            r_addr     <= bus_addr_o;
            r_wdata    <= bus_wdata_o;
            if (w_pick_if) begin
               r_starve_cnt <= '0;
            end else if (if_req_i && !r_if_done && !w_starved) begin
               r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
         end
         // An in-flight fetch cannot be retracted, so its response is swallowed instead.
         if (w_resp) begin
            r_discard <= 1'b0;
         end else if (flush_i && !r_owner_dm && r_state != S_IDLE) begin
            r_discard <= 1'b1;
         end
         if (if_rvalid_o) begin
            r_if_rdata <= bus_rdata_i;
         end
         if (dm_rvalid_o) begin
            r_dm_rdata <= bus_rdata_i;
         end
         if (flush_i || !stall_o) begin
            r_if_done <= 1'b0;
         end else if (if_rvalid_o) begin
            r_if_done <= 1'b1;
         end
         if (!stall_o) begin
            r_dm_done <= 1'b0;
         end else if (dm_rvalid_o) begin
            r_dm_done <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
